spi_slave: RTL

- SPI responder (mode 0, MSB first, 8-bit frames) for the far end of the processor's SPI master link; used as a peripheral-side endpoint and as the loopback partner in SPI integration benches.
- Oversamples sck, cs and mosi in the clk domain, shifts received bits into a byte, and drives miso from a one-byte transmit buffer loaded over a ready/load handshake.

---
 rtl/spi_slave.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// spi_slave : SPI mode-0 responder, MSB first, 8-bit frames, clk-oversampled
// Revision  : 1.0
// ============================================================================
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       underrun,
  output logic       frame_err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEL  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shreg_q, tx_shreg_d;
  logic [6:0] rx_shreg_q, rx_shreg_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;
  logic       frame_err_q, frame_err_d;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic load_next, consume, load_accept;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shreg_d  = tx_shreg_q;
    rx_shreg_d  = rx_shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    load_next   = 1'b0;
    consume     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_SEL;
          bit_cnt_d = 3'd0;
          load_next = 1'b1;
        end
      end
      ST_SEL: begin
        // Deselect wins over any sck edge seen in the same cycle.
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_err_d = (bit_cnt_q != 3'd0);
          bit_cnt_d   = 3'd0;
          tx_shreg_d  = 8'h00;
        end else if (sck_rise) begin
          rx_shreg_d = {rx_shreg_q[5:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = {rx_shreg_q, mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q != 3'd0) begin
            tx_shreg_d = {tx_shreg_q[6:0], 1'b0};
          end else begin
            load_next = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_next) begin
      if (tx_full_q) begin
        tx_shreg_d = tx_buf_q;
        consume    = 1'b1;
      end else begin
        tx_shreg_d = 8'h00;
        underrun_d = 1'b1;
      end
    end

    // A load coinciding with a consume refills the slot being emptied.
    load_accept = tx_load & (~tx_full_q | consume);
    tx_buf_d    = load_accept ? tx_data : tx_buf_q;
    tx_full_d   = load_accept | (tx_full_q & ~consume);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      tx_shreg_q  <= 8'h00;
      rx_shreg_q  <= 7'h00;
      tx_buf_q    <= 8'h00;
      tx_full_q   <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shreg_q  <= tx_shreg_d;
      rx_shreg_q  <= rx_shreg_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso      = ~cs_s & tx_shreg_q[7];
  assign busy      = ~cs_s;
  assign miso_oe   = ~cs_s;
  assign tx_ready  = ~tx_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire
